// File: rtl/hbridge_pulse_decoder_pkg.sv
// Shared definitions for the H-bridge pulse generator, its decoder and the
// width readback register: field widths, packed-word layout, fault codes and
// the decoder state type.
package hbridge_pkg;

  localparam int D1_W   = 4;
  localparam int D2_W   = 6;
  localparam int D3_W   = 6;
  localparam int WORD_W = D1_W + D2_W + D3_W;

  // Bit offsets of each field inside the packed width word.
  localparam int D1_LSB = 0;
  localparam int D2_LSB = D1_LSB + D1_W;
  localparam int D3_LSB = D2_LSB + D2_W;

  // Offset counter is one bit wider than the widest field so that running
  // past the largest encodable offset is visible.
  localparam int               CNT_W   = D3_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << D3_W) - 1);
  localparam logic [CNT_W-1:0] D1_MAX  = CNT_W'((1 << D1_W) - 1);

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ORDER   = 2'd1;
  localparam logic [1:0] FAULT_RANGE   = 2'd2;
  localparam logic [1:0] FAULT_MISSING = 2'd3;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_OUTER,
    ST_INNER,
    ST_TAIL,
    ST_DRAIN
  } state_t;

  // Assemble the width word from its three fields.
  function automatic logic [WORD_W-1:0] pack_word(input logic [D1_W-1:0] d1,
                                                  input logic [D2_W-1:0] d2,
                                                  input logic [D3_W-1:0] d3);
    logic [WORD_W-1:0] w;
    w = '0;
    w[D1_LSB +: D1_W] = d1;
    w[D2_LSB +: D2_W] = d2;
    w[D3_LSB +: D3_W] = d3;
    return w;
  endfunction

endpackage

// File: rtl/hbridge_pulse_decoder_if.sv
// Gate-drive tap and decoded-report bundle between the generator side
// (master) and the pulse decoder (slave).
interface hbridge_pulse_decoder_if;

  logic                        q1q8;
  logic                        q3q6;
  logic [hbridge_pkg::WORD_W-1:0] dataout;
  logic                        valid;
  logic [1:0]                  fault_code;
  logic                        busy;

  modport master (
    output q1q8, q3q6,
    input  dataout, valid, fault_code, busy
  );

  modport slave (
    input  q1q8, q3q6,
    output dataout, valid, fault_code, busy
  );

endinterface

// File: rtl/hbridge_pulse_decoder.sv
// Recovers the packed width word from the Q1Q8 (outer) / Q3Q6 (inner) gate
// drive pair by timing the inner edges and the outer fall against the outer
// rise, and flags frames that cannot have come from a well-formed word.
module hbridge_pulse_decoder
  import hbridge_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  hbridge_pulse_decoder_if.slave   bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [D1_W-1:0]  d1;
  logic [D2_W-1:0]  d2;

  logic a;
  logic b;
  assign a = bus.q1q8;
  assign b = bus.q3q6;

  // Frame FSM: measures edge offsets and issues one registered report per frame.
  // NOTE: all state and outputs here use non-blocking assignments so every
  // branch sees the pre-edge values of cnt/d1/d2 regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_SYNC;
      cnt            <= '0;
      d1             <= '0;
      d2             <= '0;
      bus.dataout    <= '0;
      bus.valid      <= 1'b0;
      bus.fault_code <= FAULT_NONE;
      bus.busy       <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        ST_SYNC, ST_DRAIN: begin
          if (!a && !b) state <= ST_IDLE;
        end

        ST_IDLE: begin
          d1 <= '0;
          d2 <= '0;
          if (a) begin
            cnt <= CNT_W'(1);
            if (b) begin
              bus.valid <= 1'b1; bus.fault_code <= FAULT_ORDER; bus.dataout <= '0;
              state <= ST_DRAIN;
            end else begin
              bus.busy <= 1'b1;
              state    <= ST_OUTER;
            end
          end else if (b) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_ORDER; bus.dataout <= '0;
            state <= ST_DRAIN;
          end
        end

        ST_OUTER: begin
          cnt <= cnt + 1'b1;
          if (cnt > CNT_MAX) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_RANGE; bus.dataout <= '0;
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (!a && !b) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_MISSING;
            bus.dataout <= pack_word('0, '0, cnt[D3_W-1:0]);
            bus.busy <= 1'b0; state <= ST_IDLE;
          end else if (!a) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_ORDER; bus.dataout <= '0;
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (b) begin
            if (cnt > D1_MAX) begin
              bus.valid <= 1'b1; bus.fault_code <= FAULT_RANGE; bus.dataout <= '0;
              bus.busy <= 1'b0; state <= ST_DRAIN;
            end else begin
              d1    <= cnt[D1_W-1:0];
              state <= ST_INNER;
            end
          end
        end

        ST_INNER: begin
          cnt <= cnt + 1'b1;
          if (cnt > CNT_MAX) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_RANGE;
            bus.dataout <= pack_word(d1, '0, '0);
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (!a && !b) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_NONE;
            bus.dataout <= pack_word(d1, cnt[D2_W-1:0], cnt[D3_W-1:0]);
            bus.busy <= 1'b0; state <= ST_IDLE;
          end else if (!a) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_ORDER;
            bus.dataout <= pack_word(d1, '0, '0);
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (!b) begin
            d2    <= cnt[D2_W-1:0];
            state <= ST_TAIL;
          end
        end

        ST_TAIL: begin
          cnt <= cnt + 1'b1;
          if (cnt > CNT_MAX) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_RANGE;
            bus.dataout <= pack_word(d1, d2, '0);
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (b) begin
            // A second inner pulse is malformed even if the outer falls with it.
            bus.valid <= 1'b1; bus.fault_code <= FAULT_ORDER;
            bus.dataout <= pack_word(d1, d2, '0);
            bus.busy <= 1'b0; state <= ST_DRAIN;
          end else if (!a) begin
            bus.valid <= 1'b1; bus.fault_code <= FAULT_NONE;
            bus.dataout <= pack_word(d1, d2, cnt[D3_W-1:0]);
            bus.busy <= 1'b0; state <= ST_IDLE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= ST_SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_pulse_decoder.sv
// Self-checking bench for hbridge_pulse_decoder: directed frames from the
// decoder's test plan plus randomized frames, all compared every cycle against
// an offset-based reference model of the frame rules.
module tb_hbridge_pulse_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hbridge_pulse_decoder_if bus ();

  hbridge_pulse_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: wait for an all-low sample, ready for a frame, or inside a frame.
  localparam int M_WAIT  = 0;
  localparam int M_READY = 1;
  localparam int M_FRAME = 2;

  typedef struct {
    int          mode;
    int          k;      // offset of the sample being taken
    int          r;      // inner rise offset, -1 if not seen
    int          f;      // inner fall offset, -1 if not seen
    bit          exp_valid;
    logic [1:0]  exp_fault;
    logic [15:0] exp_word;
    bit          exp_busy;
  } model_t;

  function automatic logic [15:0] word_of(input int d1, input int d2, input int d3);
    return 16'(d3 * 1024 + d2 * 16 + d1);
  endfunction

  function automatic model_t rep(input model_t x, input int fault, input logic [15:0] w,
                                 input int next_mode);
    model_t y = x;
    y.exp_valid = 1'b1;
    y.exp_fault = 2'(fault);
    y.exp_word  = w;
    y.mode      = next_mode;
    return y;
  endfunction

  function automatic model_t model_step(input model_t cur, input logic a, input logic b);
    model_t n = cur;
    int k, d1, d2;
    n.exp_valid = 1'b0;
    case (cur.mode)
      M_WAIT: if (!a && !b) n.mode = M_READY;
      M_READY: begin
        if (a) begin
          n.k = 1; n.r = -1; n.f = -1;
          if (b) n = rep(n, 1, 16'h0, M_WAIT);
          else   n.mode = M_FRAME;
        end else if (b) begin
          n = rep(n, 1, 16'h0, M_WAIT);
        end
      end
      default: begin
        k  = cur.k;
        d1 = (cur.r > 0) ? cur.r : 0;
        d2 = (cur.f > 0) ? cur.f : 0;
        n.k = k + 1;
        if (k > 63) begin
          n = rep(n, 2, word_of(d1, d2, 0), M_WAIT);
        end else if (cur.r < 0) begin
          if (!a && !b)    n = rep(n, 3, word_of(0, 0, k), M_READY);
          else if (!a)     n = rep(n, 1, 16'h0, M_WAIT);
          else if (b) begin
            if (k > 15)    n = rep(n, 2, 16'h0, M_WAIT);
            else           n.r = k;
          end
        end else if (cur.f < 0) begin
          if (!a && !b)    n = rep(n, 0, word_of(d1, k, k), M_READY);
          else if (!a)     n = rep(n, 1, word_of(d1, 0, 0), M_WAIT);
          else if (!b)     n.f = k;
        end else begin
          if (b)           n = rep(n, 1, word_of(d1, d2, 0), M_WAIT);
          else if (!a)     n = rep(n, 0, word_of(d1, d2, k), M_READY);
        end
      end
    endcase
    n.exp_busy = (n.mode == M_FRAME);
    return n;
  endfunction

  localparam model_t M_RESET = '{mode: M_WAIT, k: 0, r: -1, f: -1, exp_valid: 1'b0,
                                 exp_fault: 2'd0, exp_word: 16'h0, exp_busy: 1'b0};

  model_t m = M_RESET;

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= M_RESET;
    else        m <= model_step(m, bus.q1q8, bus.q3q6);
  end

  // ---------------- compare / report monitor ----------------
  int          rep_cnt = 0;
  logic [15:0] last_word = '0;
  logic [1:0]  last_fault = '0;
  logic [15:0] mdl_word = '0;

  always @(negedge clk) begin
    check("valid", 32'(bus.valid), 32'(m.exp_valid));
    check("busy", 32'(bus.busy), 32'(m.exp_busy));
    check("dataout", 32'(bus.dataout), 32'(m.exp_word));
    check("fault_code", 32'(bus.fault_code), 32'(m.exp_fault));
    if (bus.valid) begin
      rep_cnt    <= rep_cnt + 1;
      last_word  <= bus.dataout;
      last_fault <= bus.fault_code;
    end
    if (m.exp_valid) mdl_word <= m.exp_word;
  end

  // ---------------- stimulus ----------------
  task automatic set(input logic a, input logic b);
    bus.q1q8 = a;
    bus.q3q6 = b;
    @(posedge clk);
    #1;
  endtask

  // Outer high on offsets [0,len), inner high on [rise,fall) (rise<0: none),
  // followed by `idle` all-low samples. Optional async reset pulse at rst_at.
  task automatic frame(input int len, input int rise, input int fall, input int idle,
                       input int rst_at);
    int stop;
    stop = (fall > len) ? fall : len;
    for (int t = 0; t < stop; t++) begin
      set(t < len, rise >= 0 && t >= rise && t < fall);
      if (t == rst_at) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
    end
    for (int t = 0; t < idle; t++) set(1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  int base;

  initial begin
    bus.q1q8 = 1'b0;
    bus.q3q6 = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dataout", 32'(bus.dataout), 32'h0);
    check("reset_valid", 32'(bus.valid), 32'h0);
    check("reset_fault", 32'(bus.fault_code), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    repeat (2) set(1'b0, 1'b0);

    // Clean word 0x50A3.
    base = rep_cnt;
    frame(20, 3, 10, 2, -1);
    settle();
    check("w50a3_count", 32'(rep_cnt - base), 32'd1);
    check("w50a3_word", 32'(last_word), 32'h50A3);
    check("w50a3_fault", 32'(last_fault), 32'd0);
    check("w50a3_model", 32'(mdl_word), 32'h50A3);

    // Async reset mid-frame clears outputs at once.
    set(1'b1, 1'b0);
    set(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_dataout", 32'(bus.dataout), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    #1;
    reset = 1'b1;
    frame(6, -1, -1, 2, -1);

    // Missing inner pulse.
    frame(12, -1, -1, 2, -1);
    settle();
    check("missing_word", 32'(last_word), 32'h3000);
    check("missing_fault", 32'(last_fault), 32'd3);
    check("missing_model", 32'(mdl_word), 32'h3000);

    // Inner rise too late for d1, single report.
    base = rep_cnt;
    frame(30, 16, 20, 2, -1);
    settle();
    check("late_d1_count", 32'(rep_cnt - base), 32'd1);
    check("late_d1_word", 32'(last_word), 32'h0);
    check("late_d1_fault", 32'(last_fault), 32'd2);

    // Counter overflow with d1/d2 captured.
    base = rep_cnt;
    frame(70, 2, 5, 2, -1);
    settle();
    check("ovf_count", 32'(rep_cnt - base), 32'd1);
    check("ovf_word", 32'(last_word), 32'h0052);
    check("ovf_fault", 32'(last_fault), 32'd2);
    check("ovf_model", 32'(mdl_word), 32'h0052);

    // Inner pulse with outer low.
    base = rep_cnt;
    set(1'b0, 1'b1);
    set(1'b0, 1'b1);
    set(1'b0, 1'b0);
    settle();
    check("order_idle_count", 32'(rep_cnt - base), 32'd1);
    check("order_idle_fault", 32'(last_fault), 32'd1);

    // Inner still high when outer falls.
    base = rep_cnt;
    frame(10, 3, 14, 2, -1);
    settle();
    check("order_fall_count", 32'(rep_cnt - base), 32'd1);
    check("order_fall_word", 32'(last_word), 32'h0003);
    check("order_fall_fault", 32'(last_fault), 32'd1);

    // Back-to-back frames with one idle sample between them.
    base = rep_cnt;
    frame(8, 2, 4, 1, -1);
    frame(9, 1, 5, 2, -1);
    settle();
    check("b2b_count", 32'(rep_cnt - base), 32'd2);
    check("b2b_word", 32'(last_word), 32'(word_of(1, 5, 9)));

    // Reset released during a frame: that frame is ignored.
    reset = 1'b0;
    bus.q1q8 = 1'b1;
    bus.q3q6 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    base = rep_cnt;
    repeat (4) set(1'b1, 1'b0);
    repeat (3) set(1'b1, 1'b1);
    set(1'b0, 1'b0);
    settle();
    check("sync_no_report", 32'(rep_cnt - base), 32'd0);
    frame(20, 3, 10, 2, -1);
    settle();
    check("sync_next_count", 32'(rep_cnt - base), 32'd1);
    check("sync_next_word", 32'(last_word), 32'h50A3);

    // Randomized frames, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      int len, rise, fall, idle, rst_at;
      len  = $urandom_range(1, 70);
      rise = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, len + 1));
      fall = (rise < 0) ? -1 : rise + int'($urandom_range(1, 20));
      idle = $urandom_range(1, 4);
      rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len)) : -1;
      frame(len, rise, fall, idle, rst_at);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
